// File: rtl/key_pkg.sv
// Shared types for the key debounce block.
// State encoding and counter-width helper.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } key_st_e;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce_unit.sv
// One key: 2-flop sync, debounce FSM, hold counter, led toggle.
// Ports: sys_clk, sys_rst, key (active-low) -> key_state/press/release/long, led.
module key_debounce_unit
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 1000000,
  parameter int LONG_CNT     = 50000000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic led
);

  localparam int DB_W   = cnt_w(DEBOUNCE_CNT);
  localparam int HOLD_W = cnt_w(LONG_CNT);
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CNT - 1);

  logic key_s1, key_s2;

  key_st_e state_q, state_nxt;
  logic [DB_W-1:0]   db_cnt, db_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic long_done, done_nxt;
  logic press_nxt, rel_nxt, long_nxt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      long_done   <= 1'b0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      led         <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      db_cnt      <= db_nxt;
      hold_cnt    <= hold_nxt;
      long_done   <= done_nxt;
      key_state   <= (state_nxt == PRESSED) ||
                     (state_nxt == RELEASE_DB);
      key_press   <= press_nxt;
      key_release <= rel_nxt;
      key_long    <= long_nxt;
      led         <= led ^ press_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    db_nxt    = db_cnt;
    hold_nxt  = hold_cnt;
    done_nxt  = long_done;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    long_nxt  = 1'b0;

    // Hold time runs through release bounces; long fires once
    // on the first cycle the saturated count is seen.
    if (state_q == PRESSED || state_q == RELEASE_DB) begin
      if (hold_cnt != HOLD_MAX)
        hold_nxt = hold_cnt + 1'b1;
      else if (!long_done) begin
        long_nxt = 1'b1;
        done_nxt = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (!key_s2) begin
          state_nxt = PRESS_DB;
          db_nxt    = '0;
        end
      end
      PRESS_DB: begin
        if (key_s2)
          state_nxt = IDLE;
        else if (db_cnt == DB_MAX) begin
          state_nxt = PRESSED;
          press_nxt = 1'b1;
          hold_nxt  = '0;
          done_nxt  = 1'b0;
        end else
          db_nxt = db_cnt + 1'b1;
      end
      PRESSED: begin
        if (key_s2) begin
          state_nxt = RELEASE_DB;
          db_nxt    = '0;
        end
      end
      RELEASE_DB: begin
        if (!key_s2)
          state_nxt = PRESSED;
        else if (db_cnt == DB_MAX) begin
          state_nxt = IDLE;
          rel_nxt   = 1'b1;
        end else
          db_nxt = db_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/key_debounce_ctrl.sv
// Debounced multi-key controller with press/release/long pulses.
// Ports: sys_clk, sys_rst, key[N] (active-low) -> per-key outputs.
module key_debounce_ctrl
  import key_pkg::*;
#(
  parameter int KEY_NUM      = 2,
  parameter int DEBOUNCE_CNT = 1000000,
  parameter int LONG_CNT     = 50000000
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] led
);

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    key_debounce_unit #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .LONG_CNT    (LONG_CNT)
    ) u_unit (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .key        (key[i]),
      .key_state  (key_state[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i]),
      .led        (led[i])
    );
  end

endmodule
